// File: rtl/pkt_dma_sched.sv
// Packet capture DMA scheduler: splits accepted packets into burst-sized chunks that
// never straddle the capture ring end, and handshakes each chunk with the read and write controllers.
`timescale 1ns/1ps
module pkt_dma_sched #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned RING_SIZE = 4096,
  parameter logic [ADDR_W-1:0] RING_BASE = ADDR_W'(32'h1000_0000),
  localparam int unsigned PTR_W    = $clog2(RING_SIZE),
  localparam int unsigned CL_W     = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic [PTR_W-1:0]  host_rd_ptr,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CL_W-1:0]   chunk_len,
  input  logic              rd_done,
  input  logic              wr_done,
  output logic              pkt_done,
  output logic [31:0]       pkt_count,
  output logic [15:0]       drop_count,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic              busy
);

  localparam int unsigned CMP_W = (LEN_W > PTR_W) ? LEN_W : PTR_W;
  localparam int unsigned MW_A  = (LEN_W > PTR_W + 1) ? LEN_W : PTR_W + 1;
  localparam int unsigned MW    = (MW_A > CL_W) ? MW_A : CL_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHUNK = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [LEN_W-1:0]    r_rem;
  logic                r_rd_done;
  logic                r_wr_done;

  logic [PTR_W-1:0]    w_free;
  logic                w_accept;
  logic                w_drop;
  logic                w_rd_seen;
  logic                w_wr_seen;
  logic [ADDR_W-1:0]   w_next_src;
  logic [LEN_W-1:0]    w_next_rem;
  logic [PTR_W-1:0]    w_next_wp;

  // Chunk size: bounded by what is left, the burst limit and the distance to the ring end.
  function automatic logic [CL_W-1:0] f_chunk(input logic [LEN_W-1:0] rem,
                                              input logic [PTR_W-1:0] wp);
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [MW-1:0] c;
    logic [MW-1:0] m;
    a = MW'(rem);
    b = MW'(MAX_BURST);
    c = MW'(RING_SIZE) - MW'(wp);
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return CL_W'(m);
  endfunction

  assign desc_ready = enable && (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);

  // One byte of the ring is always left unused so full and empty differ.
  assign w_free     = PTR_W'(RING_SIZE - 1) - (wr_ptr - host_rd_ptr);
  assign w_accept   = desc_valid && desc_ready;
  assign w_drop     = (desc_len == '0) || (CMP_W'(desc_len) > CMP_W'(w_free));

  assign w_rd_seen  = r_rd_done || rd_done;
  assign w_wr_seen  = r_wr_done || wr_done;
  assign w_next_src = r_src + ADDR_W'(chunk_len);
  assign w_next_rem = r_rem - LEN_W'(chunk_len);
  assign w_next_wp  = wr_ptr + PTR_W'(chunk_len);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_rem      <= '0;
      r_rd_done  <= 1'b0;
      r_wr_done  <= 1'b0;
      rd_start   <= 1'b0;
      wr_start   <= 1'b0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      chunk_len  <= '0;
      pkt_done   <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
      wr_ptr     <= '0;
    end else begin
      rd_start <= 1'b0;
      wr_start <= 1'b0;
      pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_drop) begin
              if (drop_count != '1) drop_count <= 16'(drop_count + 16'd1);
            end else begin
              r_src     <= desc_addr;
              r_rem     <= desc_len;
              rd_addr   <= desc_addr;
              wr_addr   <= RING_BASE + ADDR_W'(wr_ptr);
              chunk_len <= f_chunk(desc_len, wr_ptr);
              rd_start  <= 1'b1;
              wr_start  <= 1'b1;
              r_state   <= S_CHUNK;
            end
          end
        end
        S_CHUNK: r_state <= S_WAIT;
        S_WAIT: begin
          // Completions are latched separately; the chunk retires only once both are in.
          if (w_rd_seen && w_wr_seen) begin
            r_src     <= w_next_src;
            r_rem     <= w_next_rem;
            wr_ptr    <= w_next_wp;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            if (w_next_rem == '0) begin
              pkt_done <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              rd_addr   <= w_next_src;
              wr_addr   <= RING_BASE + ADDR_W'(w_next_wp);
              chunk_len <= f_chunk(w_next_rem, w_next_wp);
              rd_start  <= 1'b1;
              wr_start  <= 1'b1;
              r_state   <= S_CHUNK;
            end
          end else begin
            r_rd_done <= w_rd_seen;
            r_wr_done <= w_wr_seen;
          end
        end
        S_DONE: begin
          pkt_count <= pkt_count + 32'd1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_dma_sched.sv
// Self-checking bench for pkt_dma_sched: directed ring scenarios plus randomized packets
// compared against an arithmetic chunking model of the capture ring.
`timescale 1ns/1ps
module tb_pkt_dma_sched;

  localparam int RING  = 4096;
  localparam int BURST = 256;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_addr;
  logic [15:0] desc_len;
  logic [11:0] host_rd_ptr;
  logic        rd_start;
  logic [31:0] rd_addr;
  logic        wr_start;
  logic [31:0] wr_addr;
  logic [8:0]  chunk_len;
  logic        rd_done;
  logic        wr_done;
  logic        pkt_done;
  logic [31:0] pkt_count;
  logic [15:0] drop_count;
  logic [11:0] wr_ptr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pkt_dma_sched dut (
    .clk(clk), .reset(reset), .enable(enable),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_len(desc_len), .host_rd_ptr(host_rd_ptr),
    .rd_start(rd_start), .rd_addr(rd_addr), .wr_start(wr_start), .wr_addr(wr_addr),
    .chunk_len(chunk_len), .rd_done(rd_done), .wr_done(wr_done),
    .pkt_done(pkt_done), .pkt_count(pkt_count), .drop_count(drop_count),
    .wr_ptr(wr_ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ra;
    logic [31:0] wa;
    logic [8:0]  cl;
    logic        ws;
    int          cyc;
  } chunk_t;

  chunk_t obs_q[$];
  chunk_t exp_q[$];
  int cyc = 0;
  int done_cnt = 0;

  // Reference ring state
  int m_wp, m_pkt, m_drop;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_start) obs_q.push_back('{rd_addr, wr_addr, chunk_len, wr_start, cyc});
    if (pkt_done) done_cnt++;
  end

  function automatic int model_free(input int wp, input int hrd);
    return RING - (((wp - hrd) % RING + RING) % RING) - 1;
  endfunction

  function automatic void build_exp(input logic [31:0] src, input int len);
    int rem;
    int c;
    logic [31:0] s;
    exp_q.delete();
    rem = len;
    s = src;
    while (rem > 0) begin
      c = rem;
      if (c > BURST) c = BURST;
      if (c > RING - m_wp) c = RING - m_wp;
      exp_q.push_back('{s, BASE + 32'(m_wp), 9'(c), 1'b1, 0});
      s = s + 32'(c);
      m_wp = (m_wp + c) % RING;
      rem = rem - c;
    end
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    desc_valid = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    obs_q.delete();
    done_cnt = 0;
  endtask

  // Offers one descriptor (caller is at a negedge with desc_ready high) and answers
  // each chunk with done pulses after the given lags; a lag of 0 picks one at random.
  task automatic drive_pkt(input logic [31:0] src, input int len,
                           input int lr0, input int lw0, input int lr1, input int lw1);
    int n, k, lr, lw, m;
    n = 0;
    k = 0;
    obs_q.delete();
    done_cnt = 0;
    desc_addr = src;
    desc_len = 16'(len);
    desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    while (busy && n < 400) begin
      if (rd_start) begin
        lr = (k == 0) ? lr0 : lr1;
        lw = (k == 0) ? lw0 : lw1;
        if (lr == 0) lr = int'($urandom_range(1, 4));
        if (lw == 0) lw = int'($urandom_range(1, 4));
        m = (lr > lw) ? lr : lw;
        for (int j = 1; j <= m; j++) begin
          @(negedge clk);
          n++;
          rd_done = (j == lr);
          wr_done = (j == lw);
        end
        @(negedge clk);
        n++;
        rd_done = 1'b0;
        wr_done = 1'b0;
        k++;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drive_timeout busy=%0b required 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_start, wr_start, pkt_done, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b required 0000", {rd_start, wr_start, pkt_done, busy});
    end
    checks++;
    if ({rd_addr, wr_addr, chunk_len} !== '0) begin
      errors++;
      $display("FAIL reset_addrs rd=%h wr=%h len=%0d required 0", rd_addr, wr_addr, chunk_len);
    end
    checks++;
    if ({pkt_count, drop_count, wr_ptr} !== '0) begin
      errors++;
      $display("FAIL reset_counters pkt=%0d drop=%0d wp=%0d required 0", pkt_count, drop_count, wr_ptr);
    end
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", desc_ready);
    end
  endtask

  task automatic test_split();
    logic [31:0] e_ra [3];
    logic [31:0] e_wa [3];
    int          e_cl [3];
    e_ra = '{32'h2000, 32'h2100, 32'h2200};
    e_wa = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200};
    e_cl = '{256, 256, 88};
    do_reset();
    host_rd_ptr = 12'd0;
    drive_pkt(32'h2000, 600, 0, 0, 0, 0);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL split_nchunks got %0d required 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i].ra !== e_ra[i] || obs_q[i].wa !== e_wa[i] || obs_q[i].cl !== 9'(e_cl[i]) || obs_q[i].ws !== 1'b1) begin
          errors++;
          $display("FAIL split_chunk%0d got rd=%h wr=%h len=%0d ws=%b required rd=%h wr=%h len=%0d ws=1",
                   i, obs_q[i].ra, obs_q[i].wa, obs_q[i].cl, obs_q[i].ws, e_ra[i], e_wa[i], e_cl[i]);
        end
      end
    end
    checks++;
    if (pkt_count !== 32'd1 || wr_ptr !== 12'd600 || done_cnt != 1) begin
      errors++;
      $display("FAIL split_final pkt=%0d wp=%0d dones=%0d required 1/600/1", pkt_count, wr_ptr, done_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    host_rd_ptr = 12'd0;
    drive_pkt(32'h0, 4000, 0, 0, 0, 0);
    checks++;
    if (wr_ptr !== 12'd4000) begin
      errors++;
      $display("FAIL wrap_setup wp=%0d required 4000", wr_ptr);
    end
    host_rd_ptr = 12'd3000;
    drive_pkt(32'h5000, 200, 0, 0, 0, 0);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL wrap_nchunks got %0d required 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].wa !== 32'h1000_0FA0 || obs_q[0].cl !== 9'd96 || obs_q[0].ra !== 32'h5000) begin
        errors++;
        $display("FAIL wrap_chunk0 got wr=%h len=%0d rd=%h required 10000fa0/96/5000", obs_q[0].wa, obs_q[0].cl, obs_q[0].ra);
      end
      checks++;
      if (obs_q[1].wa !== 32'h1000_0000 || obs_q[1].cl !== 9'd104 || obs_q[1].ra !== 32'h5060) begin
        errors++;
        $display("FAIL wrap_chunk1 got wr=%h len=%0d rd=%h required 10000000/104/5060", obs_q[1].wa, obs_q[1].cl, obs_q[1].ra);
      end
    end
    checks++;
    if (wr_ptr !== 12'd104 || pkt_count !== 32'd2) begin
      errors++;
      $display("FAIL wrap_final wp=%0d pkt=%0d required 104/2", wr_ptr, pkt_count);
    end
  endtask

  task automatic test_full();
    do_reset();
    host_rd_ptr = 12'd0;
    drive_pkt(32'h100, 100, 0, 0, 0, 0);
    host_rd_ptr = 12'd200;
    drive_pkt(32'h300, 100, 0, 0, 0, 0);
    checks++;
    if (drop_count !== 16'd1 || obs_q.size() != 0 || done_cnt != 0 || wr_ptr !== 12'd100) begin
      errors++;
      $display("FAIL full_drop drop=%0d chunks=%0d dones=%0d wp=%0d required 1/0/0/100",
               drop_count, obs_q.size(), done_cnt, wr_ptr);
    end
    drive_pkt(32'h300, 99, 0, 0, 0, 0);
    checks++;
    if (drop_count !== 16'd1 || obs_q.size() != 1 || wr_ptr !== 12'd199 || pkt_count !== 32'd2) begin
      errors++;
      $display("FAIL full_fit drop=%0d chunks=%0d wp=%0d pkt=%0d required 1/1/199/2",
               drop_count, obs_q.size(), wr_ptr, pkt_count);
    end
  endtask

  task automatic test_done_order();
    do_reset();
    host_rd_ptr = 12'd0;
    // Stray completion while idle must not pre-satisfy the first chunk.
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    @(negedge clk);
    drive_pkt(32'h8000, 700, 4, 1, 2, 2);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL order_nchunks got %0d required 3", obs_q.size());
    end else begin
      checks++;
      if (obs_q[1].cyc - obs_q[0].cyc != 5) begin
        errors++;
        $display("FAIL order_gap_split got %0d required 5", obs_q[1].cyc - obs_q[0].cyc);
      end
      checks++;
      if (obs_q[2].cyc - obs_q[1].cyc != 3) begin
        errors++;
        $display("FAIL order_gap_same got %0d required 3", obs_q[2].cyc - obs_q[1].cyc);
      end
      checks++;
      if (obs_q[2].cl !== 9'd188 || obs_q[2].ra !== 32'h8200) begin
        errors++;
        $display("FAIL order_last len=%0d rd=%h required 188/8200", obs_q[2].cl, obs_q[2].ra);
      end
    end
    checks++;
    if (wr_ptr !== 12'd700 || pkt_count !== 32'd1 || done_cnt != 1) begin
      errors++;
      $display("FAIL order_final wp=%0d pkt=%0d dones=%0d required 700/1/1", wr_ptr, pkt_count, done_cnt);
    end
  endtask

  task automatic test_zero_enable();
    do_reset();
    host_rd_ptr = 12'd0;
    drive_pkt(32'h0, 0, 0, 0, 0, 0);
    checks++;
    if (drop_count !== 16'd1 || obs_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len drop=%0d chunks=%0d busy=%b required 1/0/0", drop_count, obs_q.size(), busy);
    end
    fork
      drive_pkt(32'h4000, 300, 0, 0, 0, 0);
      begin
        @(negedge clk);
        enable = 1'b0;
      end
    join
    checks++;
    if (pkt_count !== 32'd1 || wr_ptr !== 12'd300 || obs_q.size() != 2) begin
      errors++;
      $display("FAIL enable_off_pkt pkt=%0d wp=%0d chunks=%0d required 1/300/2", pkt_count, wr_ptr, obs_q.size());
    end
    obs_q.delete();
    desc_addr = 32'h9000;
    desc_len = 16'd10;
    desc_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (desc_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL enable_off_ready ready=%b busy=%b required 0/0", desc_ready, busy);
      end
    end
    checks++;
    if (obs_q.size() != 0 || drop_count !== 16'd1) begin
      errors++;
      $display("FAIL enable_off_accept chunks=%0d drop=%0d required 0/1", obs_q.size(), drop_count);
    end
    desc_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    host_rd_ptr = 12'd0;
    drive_pkt(32'h100, 100, 0, 0, 0, 0);
    drive_pkt(32'h0, 0, 0, 0, 0, 0);
    desc_addr = 32'h7000;
    desc_len = 16'd300;
    desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    @(negedge clk);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    obs_q.delete();
    done_cnt = 0;
    @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || obs_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL rstmid_state busy=%b chunks=%0d dones=%0d required 0/0/0", busy, obs_q.size(), done_cnt);
    end
    checks++;
    if (pkt_count !== 32'd0 || drop_count !== 16'd0 || wr_ptr !== 12'd0) begin
      errors++;
      $display("FAIL rstmid_counters pkt=%0d drop=%0d wp=%0d required 0/0/0", pkt_count, drop_count, wr_ptr);
    end
  endtask

  task automatic test_random();
    logic [31:0] src;
    int len, fr, bad;
    logic drop;
    do_reset();
    m_wp = 0;
    m_pkt = 0;
    m_drop = 0;
    for (int p = 0; p < 40; p++) begin
      host_rd_ptr = 12'($urandom_range(0, RING - 1));
      src = $urandom;
      if ($urandom_range(0, 5) == 0) len = int'($urandom_range(0, 20));
      else len = int'($urandom_range(1, 4200));
      fr = model_free(m_wp, int'(host_rd_ptr));
      drop = (len == 0) || (len > fr);
      if (drop) begin
        exp_q.delete();
        m_drop++;
      end else begin
        build_exp(src, len);
        m_pkt++;
      end
      drive_pkt(src, len, 0, 0, 0, 0);
      bad = 0;
      if (obs_q.size() != exp_q.size()) bad = 1;
      else
        for (int i = 0; i < exp_q.size(); i++)
          if (obs_q[i].ra !== exp_q[i].ra || obs_q[i].wa !== exp_q[i].wa ||
              obs_q[i].cl !== exp_q[i].cl || obs_q[i].ws !== 1'b1) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_chunks pkt %0d len=%0d got %0d chunks required %0d (wp model %0d)",
                 p, len, obs_q.size(), exp_q.size(), m_wp);
      end
      checks++;
      if (wr_ptr !== 12'(m_wp) || pkt_count !== 32'(m_pkt) || drop_count !== 16'(m_drop) ||
          done_cnt != (drop ? 0 : 1)) begin
        errors++;
        $display("FAIL rand_state pkt %0d got wp=%0d pkt=%0d drop=%0d dones=%0d required %0d/%0d/%0d/%0d",
                 p, wr_ptr, pkt_count, drop_count, done_cnt, m_wp, m_pkt, m_drop, drop ? 0 : 1);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    desc_valid = 1'b0;
    desc_addr = '0;
    desc_len = '0;
    host_rd_ptr = '0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_split();
    test_wrap();
    test_full();
    test_done_order();
    test_zero_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_dma_sched.md
PKT_DMA_SCHED -- requirements
Module: pkt_dma_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter LEN_W, default 16, packet length width in bytes.
REQ-003 SHALL have parameter MAX_BURST, default 256, maximum chunk size in bytes; power of two.
REQ-004 SHALL have parameter RING_SIZE, default 4096, capture ring size in bytes; power of two.
REQ-005 SHALL have parameter RING_BASE, default 32'h1000_0000, capture ring base address.
REQ-006 SHALL have the following ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  permits descriptor acceptance.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  descriptor accepted when high with desc_valid.
- desc_addr  in  ADDR_W  packet source address.
- desc_len  in  LEN_W  packet length in bytes.
- host_rd_ptr  in  log2(RING_SIZE)  host consumer offset into the ring.
- rd_start  out  1  one-cycle chunk read request.
- rd_addr  out  ADDR_W  chunk source address.
- wr_start  out  1  one-cycle chunk write request.
- wr_addr  out  ADDR_W  chunk destination address.
- chunk_len  out  log2(MAX_BURST)+1  chunk length for both controllers.
- rd_done  in  1  read controller chunk-complete pulse.
- wr_done  in  1  write controller chunk-complete pulse.
- pkt_done  out  1  one-cycle pulse on packet completion.
- pkt_count  out  32  packets stored.
- drop_count  out  16  packets dropped.
- wr_ptr  out  log2(RING_SIZE)  producer offset into the ring.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-007 SHALL implement an FSM with states IDLE, CHUNK, WAIT and DONE; outputs SHALL be decoded from the registered state.
REQ-008 SHALL drive desc_ready = enable && (state == IDLE).
REQ-009 SHALL compute free = RING_SIZE - ((wr_ptr - host_rd_ptr) mod RING_SIZE) - 1, keeping a one-byte gap so that full and empty are distinct.
REQ-010 On acceptance with desc_len == 0 or desc_len > free, SHALL increment drop_count (saturating at 0xFFFF), stay in IDLE and issue no requests.
REQ-011 On any other acceptance, SHALL latch src = desc_addr and remaining = desc_len, and SHALL enter CHUNK.
REQ-012 In CHUNK, SHALL set chunk_len = min(remaining, MAX_BURST, RING_SIZE - wr_ptr), so that no chunk crosses the ring end.
REQ-013 In CHUNK, SHALL assert rd_start and wr_start for exactly one cycle with rd_addr = src and wr_addr = RING_BASE + wr_ptr, then enter WAIT.
REQ-014 rd_start SHALL appear in the cycle after the acceptance edge.
REQ-015 In WAIT, SHALL latch rd_done and wr_done independently; the two pulses may arrive in either order, in the same cycle, or in the same cycle the other is already latched.
REQ-016 In the cycle both completions are seen, SHALL perform the following updates:
- src += chunk_len.
- wr_ptr = (wr_ptr + chunk_len) mod RING_SIZE.
- remaining -= chunk_len.
- Clear both done latches.
- Go to DONE if remaining == 0, otherwise to CHUNK.
REQ-017 SHALL ignore rd_done and wr_done outside WAIT.
REQ-018 In DONE, SHALL pulse pkt_done, increment pkt_count (wrapping), and return to IDLE.
REQ-019 Deasserting enable mid-packet SHALL NOT abort the packet; it SHALL only block the next acceptance.
REQ-020 While in CHUNK, rd_addr, wr_addr and chunk_len SHALL hold stable for the whole cycle.

Reset
REQ-021 On reset low at a clk edge, SHALL enter IDLE and clear the following to 0: rd_start, wr_start, rd_addr, wr_addr, chunk_len, pkt_done, pkt_count, drop_count, wr_ptr, busy, and both done latches.
REQ-022 Reset asserted mid-packet SHALL abandon the packet; a completion pulse arriving after reset release SHALL be ignored.

Verification
REQ-023 Bench SHALL cover the following directed scenarios with default parameters:
- Split: wr_ptr=0, host_rd_ptr=0, len=600, src=0x2000 -> chunks of 256/256/88 at wr_addr 0x10000000/0x10000100/0x10000200 and rd_addr 0x2000/0x2100/0x2200; pkt_count=1; wr_ptr=600.
- Wrap: wr_ptr=4000, host_rd_ptr=3000, len=200 -> chunk of 96 at 0x10000FA0, then chunk of 104 at 0x10000000; wr_ptr=104.
- Full: wr_ptr=100, host_rd_ptr=200 (free=99), len=100 -> drop_count=1, no rd_start; next len=99 -> accepted, wr_ptr=199.
- Done ordering: wr_done 3 cycles before rd_done, then both in the same cycle on the next chunk -> each chunk advances exactly once, only after both completions.
- Zero length and enable: len=0 -> drop_count increments; enable=0 mid-packet -> packet completes, desc_ready stays 0 afterwards.
- Reset mid-WAIT: reset asserted with rd_done latched; late wr_done pulse after release -> state IDLE, all counters 0, no pkt_done.
